// File: rtl/adpcm_decode_ctrl.sv
// adpcm_decode_ctrl: IMA ADPCM decode sequencer.
// Takes 16-bit words of four 4-bit codes and emits one signed sample per code
// over a valid/ready handshake. The predictor update itself is done by an
// external combinational inverse quantizer (q_prev/q_code/q_step -> q_pred).
// This block owns the predictor, the step index and the step table.
// Optional build macro: ADPCM_DECODE_HDR_EN. When it is defined, the first word
// after reset or init loads the predictor and the second word loads the index.
module adpcm_decode_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        init_valid,
    input  logic [15:0] init_pred,
    input  logic [6:0]  init_index,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sample,
    output logic [15:0] q_prev,
    output logic [3:0]  q_code,
    output logic [15:0] q_step,
    input  logic [15:0] q_pred,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EMIT   = 2'd2
    } state_t;

    localparam logic [15:0] STEP_TABLE [89] = '{
        16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
        16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
        16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
        16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
        16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
        16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
        16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
        16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
        16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
        16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
        16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
        16'd32767
    };

    function automatic logic [6:0] clamp_index(input logic [6:0] v);
        return (v > 7'd88) ? 7'd88 : v;
    endfunction

    state_t            state, state_nxt;
    logic [15:0]       word_q;
    logic [1:0]        nib_cnt;
    logic [15:0]       pred_q;
    logic [6:0]        index_q;
    logic [15:0]       sample_q;
    logic              accept_word, load_init, do_decode, advance;
    logic              hdr_take;
    logic signed [7:0] adj, idx_sum;
    logic [6:0]        idx_next;

`ifdef ADPCM_DECODE_HDR_EN
    // 0: next word is predictor, 1: next word is index, 2: header done
    logic [1:0] hdr_phase;
    assign hdr_take = (hdr_phase != 2'd2);

    // Header phase tracking, restarted by reset and by init
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_phase <= '0;
        end else if (load_init) begin
            hdr_phase <= '0;
        end else if (accept_word && hdr_take) begin
            hdr_phase <= hdr_phase + 2'd1;
        end
    end
`else
    assign hdr_take = 1'b0;
`endif

    assign q_prev     = pred_q;
    assign q_code     = word_q[{nib_cnt, 2'b00} +: 4];
    assign q_step     = STEP_TABLE[index_q];
    assign out_sample = sample_q;
    assign busy       = (state != IDLE);

    // Step-index adaptation from the current code magnitude, clamped to 0..88
    always_comb begin
        adj = -8'sd1;
        case (q_code[2:0])
            3'd4:    adj = 8'sd2;
            3'd5:    adj = 8'sd4;
            3'd6:    adj = 8'sd6;
            3'd7:    adj = 8'sd8;
            default: adj = -8'sd1;
        endcase
        idx_sum = $signed({1'b0, index_q}) + adj;
        if (idx_sum < 8'sd0) begin
            idx_next = '0;
        end else if (idx_sum > 8'sd88) begin
            idx_next = 7'd88;
        end else begin
            idx_next = idx_sum[6:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, handshake outputs and datapath strobes
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        accept_word = 1'b0;
        load_init   = 1'b0;
        do_decode   = 1'b0;
        advance     = 1'b0;
        case (state)
            IDLE: begin
                if (init_valid) begin
                    load_init = 1'b1;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept_word = 1'b1;
                        if (!hdr_take) begin
                            state_nxt = DECODE;
                        end
                    end
                end
            end
            DECODE: begin
                do_decode = 1'b1;
                state_nxt = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    advance   = 1'b1;
                    state_nxt = (nib_cnt == 2'd3) ? IDLE : DECODE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word, nibble counter, predictor, index and output sample registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q   <= '0;
            nib_cnt  <= '0;
            pred_q   <= '0;
            index_q  <= '0;
            sample_q <= '0;
        end else begin
            if (load_init) begin
                pred_q  <= init_pred;
                index_q <= clamp_index(init_index);
            end
`ifdef ADPCM_DECODE_HDR_EN
            if (accept_word && hdr_take) begin
                if (hdr_phase == 2'd0) begin
                    pred_q <= in_data;
                end else begin
                    index_q <= clamp_index(in_data[6:0]);
                end
            end
`endif
            if (accept_word && !hdr_take) begin
                word_q  <= in_data;
                nib_cnt <= '0;
            end
            if (do_decode) begin
                pred_q   <= q_pred;
                sample_q <= q_pred;
                index_q  <= idx_next;
            end
            // wraps 3 -> 0 on the last nibble; reloaded on the next word anyway
            if (advance) begin
                nib_cnt <= nib_cnt + 2'd1;
            end
        end
    end

endmodule
